// File: rtl/nn_seq_ctrl.sv
// -----------------------------------------------------------------------------
// nn_seq_ctrl
//
// Sequencer for the two-layer inference datapath. One accepted start runs one
// inference:
//   L1    : stream the input/weight-1 SRAM addresses. mac1_start follows each
//           address by the SRAM read latency.
//   W1    : wait until the hidden MACs report done and every sigmoid is ready.
//           A bounded wait; expiry raises the sticky err flag.
//   L2    : stream (sel, address_2) pairs for the output MAC. The o/j counters
//           are nested and address_2 is a running increment.
//   DRAIN : let the last weight_2 word pass through the SRAM and the output-MAC
//           pipeline, then pulse done and return to IDLE.
//
// Ports
//   i_clk          single clock, rising edge
//   i_reset        asynchronous, active-high; clears all state
//   i_start        one-cycle run request, honoured only in IDLE
//   i_mac1_done    layer-1 MAC completion (looked at only in W1)
//   i_sig_ready    per-sigmoid ready flags (looked at only in W1)
//   o_busy         high in every state except IDLE
//   o_done         one-cycle pulse on normal completion
//   o_err          sticky W1 timeout flag; cleared by accepted start or reset
//   o_we           SRAM write enable, tied low (read-only sequencer)
//   o_address_1    weight-1 SRAM address (layer-1 counter)
//   o_address_2    weight-2 SRAM address (o*N_HID + j)
//   o_address_3    input SRAM address (layer-1 counter)
//   o_address_5    sigmoid LUT address, tied to zero
//   o_mac1_start   layer-1 MAC enable, aligned with SRAM read data
//   o_mac2_start   output-MAC enable, aligned with weight_2 read data
//   o_sel          hidden-output mux select, aligned with weight_2 read data
// -----------------------------------------------------------------------------
module nn_seq_ctrl #(
  parameter int N_IN     = 784,
  parameter int N_HID    = 10,
  parameter int N_OUT    = 10,
  parameter int SRAM_LAT = 1,
  parameter int L2_LAT   = 3,
  parameter int TIMEOUT  = 1023
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_start,
  input  logic        i_mac1_done,
  input  logic [9:0]  i_sig_ready,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_err,
  output logic        o_we,
  output logic [17:0] o_address_1,
  output logic [11:0] o_address_2,
  output logic [9:0]  o_address_3,
  output logic [6:0]  o_address_5,
  output logic        o_mac1_start,
  output logic        o_mac2_start,
  output logic [6:0]  o_sel
);

  // ---------------------------------------------------------------------------
  // Derived constants
  // ---------------------------------------------------------------------------
  // done must appear SRAM_LAT+L2_LAT cycles after the last layer-2 issue cycle.
  // DRAIN is entered one cycle after that issue, and the IDLE/done update costs
  // one more edge. So the DRAIN counter stops at SRAM_LAT+L2_LAT-2.
  localparam int DRAIN_LAST = SRAM_LAT + L2_LAT - 2;
  localparam int CNT_MAX    = (TIMEOUT > DRAIN_LAST) ? TIMEOUT : DRAIN_LAST;
  localparam int CNT_W      = (CNT_MAX < 1) ? 1 : $clog2(CNT_MAX + 1);

  localparam logic [17:0]      K_LAST  = 18'(N_IN - 1);
  localparam logic [6:0]       J_LAST  = 7'(N_HID - 1);
  localparam logic [11:0]      O_LAST  = 12'(N_OUT - 1);
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] DR_LAST = CNT_W'(DRAIN_LAST);

  // Counters are zero-extended onto the address ports and must never wrap
  // inside a run. Any combination that would overflow a port is illegal.
  localparam bit PARAMS_OK =
      (N_IN >= 1) && (N_IN <= 1024) &&
      (N_HID >= 1) && (N_HID <= 128) &&
      (N_OUT >= 1) && (N_OUT * N_HID <= 4096) &&
      (SRAM_LAT >= 1) && (L2_LAT >= 0) && (SRAM_LAT + L2_LAT >= 2) &&
      (TIMEOUT >= 1);

  always @(posedge i_clk) begin
    assert (PARAMS_OK)
      else $error("nn_seq_ctrl: parameter combination exceeds a port width");
  end

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  typedef enum logic [2:0] {
    S_IDLE,
    S_L1,
    S_W1,
    S_L2,
    S_DRAIN
  } state_t;

  state_t           r_state;
  logic             r_busy;
  logic             r_done;
  logic             r_err;
  logic [17:0]      r_k;       // layer-1 address counter
  logic [11:0]      r_addr2;   // running o*N_HID + j
  logic [6:0]       r_j;       // inner (hidden) counter
  logic [11:0]      r_o;       // outer (output neuron) counter
  logic [CNT_W-1:0] r_cnt;     // W1 timeout / DRAIN cycle counter

  // Delay lines that realign the enables and sel with the SRAM read data.
  logic [SRAM_LAT-1:0] r_l1_pipe;
  logic [SRAM_LAT-1:0] r_l2_pipe;
  logic [6:0]          r_sel_pipe [SRAM_LAT];

  // NOTE: continuous assigns always drive a value, so these decode wires can
  // never infer a latch the way a partially assigned combinational process can.
  logic w_start_ok;
  logic w_w1_exit;
  logic w_l1_issue;
  logic w_l2_issue;

  // start is refused while the done pulse is showing, even though the state is
  // already IDLE. A new request is accepted one cycle later.
  assign w_start_ok = i_start && (r_state == S_IDLE) && !r_done;
  // mac1_done and the full sigmoid mask must be seen in the same cycle.
  assign w_w1_exit  = i_mac1_done && (&i_sig_ready);
  assign w_l1_issue = (r_state == S_L1);
  assign w_l2_issue = (r_state == S_L2);

  // ---------------------------------------------------------------------------
  // Control FSM and counters
  // ---------------------------------------------------------------------------
  // NOTE: every flop below is assigned with <= so all of them sample the
  // pre-edge values. Blocking = here would let later statements see values
  // already updated in this cycle and break the counter/state ordering.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state <= S_IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
      r_k     <= '0;
      r_addr2 <= '0;
      r_j     <= '0;
      r_o     <= '0;
      r_cnt   <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_start_ok) begin
            r_state <= S_L1;
            r_busy  <= 1'b1;
            r_err   <= 1'b0;
            r_k     <= '0;
          end
        end

        S_L1: begin
          // The final address holds on the port; the counter never wraps.
          if (r_k == K_LAST) begin
            r_state <= S_W1;
            r_cnt   <= '0;
          end else begin
            r_k <= r_k + 18'd1;
          end
        end

        S_W1: begin
          if (w_w1_exit) begin
            r_state <= S_L2;
            r_addr2 <= '0;
            r_j     <= '0;
            r_o     <= '0;
          end else if (r_cnt == TO_LAST) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_err   <= 1'b1;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end

        S_L2: begin
          // address_2 advances on every issue, including the j wrap, so the
          // stream has no bubbles and no multiplier is needed.
          if (r_j == J_LAST) begin
            if (r_o == O_LAST) begin
              r_state <= S_DRAIN;
              r_cnt   <= '0;
            end else begin
              r_j     <= '0;
              r_o     <= r_o + 12'd1;
              r_addr2 <= r_addr2 + 12'd1;
            end
          end else begin
            r_j     <= r_j + 7'd1;
            r_addr2 <= r_addr2 + 12'd1;
          end
        end

        S_DRAIN: begin
          if (r_cnt == DR_LAST) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end

        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // SRAM-latency alignment
  // ---------------------------------------------------------------------------
  // Each issue cycle enters stage 0 and reaches the ports SRAM_LAT cycles later.
  // A sel stage loads only behind a valid layer-2 issue. As a result the sel
  // port keeps its last value through DRAIN and IDLE.
  // NOTE: the sel delay line is an array, but it is only SRAM_LAT entries of
  // flops, so it takes the asynchronous reset like the rest of the state. A
  // real RAM would be left unreset.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_l1_pipe <= '0;
      r_l2_pipe <= '0;
      for (int i = 0; i < SRAM_LAT; i++) begin
        r_sel_pipe[i] <= '0;
      end
    end else begin
      r_l1_pipe[0] <= w_l1_issue;
      r_l2_pipe[0] <= w_l2_issue;
      if (w_l2_issue) begin
        r_sel_pipe[0] <= r_j;
      end
      for (int i = 1; i < SRAM_LAT; i++) begin
        r_l1_pipe[i] <= r_l1_pipe[i-1];
        r_l2_pipe[i] <= r_l2_pipe[i-1];
        if (r_l2_pipe[i-1]) begin
          r_sel_pipe[i] <= r_sel_pipe[i-1];
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs: all driven straight from flops, or tied off
  // ---------------------------------------------------------------------------
  assign o_busy       = r_busy;
  assign o_done       = r_done;
  assign o_err        = r_err;
  assign o_we         = 1'b0;
  assign o_address_1  = r_k;
  assign o_address_3  = r_k[9:0];
  assign o_address_2  = r_addr2;
  assign o_address_5  = 7'd0;
  assign o_mac1_start = r_l1_pipe[SRAM_LAT-1];
  assign o_mac2_start = r_l2_pipe[SRAM_LAT-1];
  assign o_sel        = r_sel_pipe[SRAM_LAT-1];

endmodule

// File: tb/tb_nn_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_nn_seq_ctrl
//
// Directed bench for nn_seq_ctrl in its small configuration. Every run pushes
// the expected layer-1 addresses and layer-2 (sel, address_2) pairs when it
// drives start. A monitor pops one entry on each MAC enable and compares it
// with the address presented SRAM_LAT cycles earlier. The run task checks
// cycle-exact events: strobe windows, done/err cycle and busy.
// -----------------------------------------------------------------------------
module tb_nn_seq_ctrl;

  localparam int N_IN     = 4;
  localparam int N_HID    = 3;
  localparam int N_OUT    = 2;
  localparam int SRAM_LAT = 1;
  localparam int L2_LAT   = 3;
  localparam int TIMEOUT  = 8;
  localparam int BUDGET   = 60;

  typedef struct {
    logic [6:0]  sel;
    logic [11:0] addr;
  } l2_exp_t;

  logic        clk       = 1'b0;
  logic        reset     = 1'b0;
  logic        start     = 1'b0;
  logic        mac1_done = 1'b0;
  logic [9:0]  sig_ready = '0;

  logic        busy;
  logic        done;
  logic        err;
  logic        we;
  logic [17:0] address_1;
  logic [11:0] address_2;
  logic [9:0]  address_3;
  logic [6:0]  address_5;
  logic        mac1_start;
  logic        mac2_start;
  logic [6:0]  sel;

  int checks   = 0;
  int failures = 0;

  int      q_l1[$];
  l2_exp_t q_l2[$];

  logic [17:0] prev_a1 = '0;
  logic [9:0]  prev_a3 = '0;
  logic [11:0] prev_a2 = '0;

  nn_seq_ctrl #(
    .N_IN    (N_IN),
    .N_HID   (N_HID),
    .N_OUT   (N_OUT),
    .SRAM_LAT(SRAM_LAT),
    .L2_LAT  (L2_LAT),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .i_clk       (clk),
    .i_reset     (reset),
    .i_start     (start),
    .i_mac1_done (mac1_done),
    .i_sig_ready (sig_ready),
    .o_busy      (busy),
    .o_done      (done),
    .o_err       (err),
    .o_we        (we),
    .o_address_1 (address_1),
    .o_address_2 (address_2),
    .o_address_3 (address_3),
    .o_address_5 (address_5),
    .o_mac1_start(mac1_start),
    .o_mac2_start(mac2_start),
    .o_sel       (sel)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard consumer: an enable at cycle c pairs with the address issued at
  // cycle c-SRAM_LAT (SRAM_LAT is 1 here, so one sample of history is enough).
  always @(negedge clk) begin
    if (!reset) begin
      check("we_zero", 32'(we), 32'd0);
      check("address_5_zero", 32'(address_5), 32'd0);
      if (mac1_start) begin
        check("l1_pending", 32'(q_l1.size() != 0), 32'd1);
        if (q_l1.size() != 0) begin
          int k;
          k = q_l1.pop_front();
          check("l1_address_3", 32'(prev_a3), 32'(k));
          check("l1_address_1", 32'(prev_a1), 32'(k));
        end
      end
      if (mac2_start) begin
        check("l2_pending", 32'(q_l2.size() != 0), 32'd1);
        if (q_l2.size() != 0) begin
          l2_exp_t e;
          e = q_l2.pop_front();
          check("l2_sel", 32'(sel), 32'(e.sel));
          check("l2_address_2", 32'(prev_a2), 32'(e.addr));
        end
      end
    end
    prev_a1 = address_1;
    prev_a3 = address_3;
    prev_a2 = address_2;
  end

  // One inference. Called at a negedge with the DUT idle; that negedge is
  // cycle 0, where start is driven.
  //   rdy_cyc  : cycle with mac1_done=1 and sig_ready=3FF (-1: never -> timeout)
  //   part_cyc : first cycle of mac1_done=1 with sig_ready=3FE, up to rdy_cyc
  //   busy_s*  : extra start pulses while busy
  //   rst_cyc  : cycle at which reset is asserted (-1: none)
  //   chain    : drive start in the done cycle and leave it high one more cycle
  task automatic do_run(input string tag, input int rdy_cyc, input int part_cyc,
                        input int busy_s1, input int busy_s2, input int rst_cyc,
                        input bit chain);
    int first_m1 = -1;
    int last_m1  = -1;
    int first_m2 = -1;
    int last_m2  = -1;
    int exp_done;
    int exp_err;
    bit finished  = 1'b0;
    bit was_reset = 1'b0;

    if (rdy_cyc >= 0) begin
      exp_done = rdy_cyc + N_OUT * N_HID + SRAM_LAT + L2_LAT;
      exp_err  = -1;
    end else begin
      exp_done = -1;
      exp_err  = N_IN + TIMEOUT + 2;
    end

    for (int k = 0; k < N_IN; k++) q_l1.push_back(k);
    if (rdy_cyc >= 0) begin
      for (int o = 0; o < N_OUT; o++) begin
        for (int j = 0; j < N_HID; j++) begin
          l2_exp_t e;
          e.sel  = 7'(j);
          e.addr = 12'(o * N_HID + j);
          q_l2.push_back(e);
        end
      end
    end

    for (int c = 0; c <= BUDGET && !finished; c++) begin
      if (c > 0) @(negedge clk);

      if (c == 0) check({tag, "_idle_busy"}, 32'(busy), 32'd0);
      if (c == 1) begin
        check({tag, "_busy_c1"}, 32'(busy), 32'd1);
        check({tag, "_address_3_c1"}, 32'(address_3), 32'd0);
        check({tag, "_address_1_c1"}, 32'(address_1), 32'd0);
        check({tag, "_err_cleared"}, 32'(err), 32'd0);
      end
      if (mac1_start) begin
        if (first_m1 < 0) first_m1 = c;
        last_m1 = c;
      end
      if (mac2_start) begin
        if (first_m2 < 0) first_m2 = c;
        last_m2 = c;
      end

      if (done) begin
        check({tag, "_done_cycle"}, 32'(c), 32'(exp_done));
        check({tag, "_busy_at_done"}, 32'(busy), 32'd0);
        start     = chain;
        mac1_done = 1'b0;
        sig_ready = '0;
        @(negedge clk);
        check({tag, "_done_one_cycle"}, 32'(done), 32'd0);
        check({tag, "_busy_after_done"}, 32'(busy), 32'd0);
        finished = 1'b1;
      end else if (c >= 1 && err) begin
        check({tag, "_err_cycle"}, 32'(c), 32'(exp_err));
        check({tag, "_busy_at_err"}, 32'(busy), 32'd0);
        start     = 1'b0;
        mac1_done = 1'b0;
        sig_ready = '0;
        @(negedge clk);
        check({tag, "_err_sticky"}, 32'(err), 32'd1);
        check({tag, "_no_done_after_err"}, 32'(done), 32'd0);
        finished = 1'b1;
      end else begin
        start = (c == 0) || (c == busy_s1) || (c == busy_s2);
        if (c == rdy_cyc) begin
          mac1_done = 1'b1;
          sig_ready = 10'h3FF;
        end else if (part_cyc >= 0 && c >= part_cyc && c < rdy_cyc) begin
          mac1_done = 1'b1;
          sig_ready = 10'h3FE;
        end else begin
          mac1_done = 1'b0;
          sig_ready = '0;
        end

        if (c == rst_cyc) begin
          #2 reset = 1'b1;
          #1;
          check({tag, "_rst_busy"}, 32'(busy), 32'd0);
          check({tag, "_rst_done"}, 32'(done), 32'd0);
          check({tag, "_rst_err"}, 32'(err), 32'd0);
          check({tag, "_rst_mac1_start"}, 32'(mac1_start), 32'd0);
          check({tag, "_rst_mac2_start"}, 32'(mac2_start), 32'd0);
          check({tag, "_rst_address_1"}, 32'(address_1), 32'd0);
          check({tag, "_rst_address_2"}, 32'(address_2), 32'd0);
          check({tag, "_rst_address_3"}, 32'(address_3), 32'd0);
          check({tag, "_rst_sel"}, 32'(sel), 32'd0);
          q_l1.delete();
          q_l2.delete();
          start     = 1'b0;
          mac1_done = 1'b0;
          sig_ready = '0;
          @(negedge clk);
          reset     = 1'b0;
          finished  = 1'b1;
          was_reset = 1'b1;
        end
      end
    end

    check({tag, "_finished_in_budget"}, 32'(finished), 32'd1);
    if (finished && !was_reset) begin
      check({tag, "_first_mac1_start"}, 32'(first_m1), 32'(1 + SRAM_LAT));
      check({tag, "_last_mac1_start"}, 32'(last_m1), 32'(N_IN + SRAM_LAT));
      check({tag, "_first_mac2_start"}, 32'(first_m2),
            32'((rdy_cyc >= 0) ? rdy_cyc + 1 + SRAM_LAT : -1));
      check({tag, "_last_mac2_start"}, 32'(last_m2),
            32'((rdy_cyc >= 0) ? rdy_cyc + N_OUT * N_HID + SRAM_LAT : -1));
      check({tag, "_l1_all_consumed"}, 32'(q_l1.size()), 32'd0);
      check({tag, "_l2_all_consumed"}, 32'(q_l2.size()), 32'd0);
    end
  endtask

  initial begin
    #1 reset = 1'b1;
    repeat (2) @(negedge clk);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_err", 32'(err), 32'd0);
    check("reset_we", 32'(we), 32'd0);
    check("reset_mac1_start", 32'(mac1_start), 32'd0);
    check("reset_mac2_start", 32'(mac2_start), 32'd0);
    check("reset_address_1", 32'(address_1), 32'd0);
    check("reset_address_2", 32'(address_2), 32'd0);
    check("reset_address_3", 32'(address_3), 32'd0);
    check("reset_address_5", 32'(address_5), 32'd0);
    check("reset_sel", 32'(sel), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    do_run("nominal",   7, -1, -1, -1, -1, 1'b0);
    do_run("partial",   9,  7, -1, -1, -1, 1'b0);
    do_run("timeout",  -1, -1, -1, -1, -1, 1'b0);
    do_run("err_clear", 7, -1, -1, -1, -1, 1'b0);
    do_run("busy_start", 7, -1, 2, 10, -1, 1'b0);
    do_run("reset_l2",  7, -1, -1, -1, 10, 1'b0);
    do_run("fresh",     7, -1, -1, -1, -1, 1'b0);
    do_run("b2b_first", 7, -1, -1, -1, -1, 1'b1);
    do_run("b2b_second", 7, -1, -1, -1, -1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog expired");
  end

endmodule
